// File: rtl/dfe_pkg.sv
// Helpers shared by the DFE receive-chain stages: width arithmetic and saturation.
package dfe_pkg;

  typedef logic signed [63:0] sat_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // CIC growth is STAGES*log2(R) bits on top of the input width
  function automatic int acc_width(input int dw, input int stages, input int max_log2);
    return dw + stages * max_log2;
  endfunction

  function automatic sat_t sat_to_width(input sat_t v, input int w);
    sat_t hi;
    sat_t lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample stream in and decimated stream out, each a data word with a one-cycle strobe.
interface cic_decimator_if #(
  parameter int DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] x_in;
  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] y_out;
  logic                         valid_out;

  modport master (output x_in, output valid_in, input y_out, input valid_out);
  modport slave  (input x_in, input valid_in, output y_out, output valid_out);
endinterface

// File: rtl/cic_decimator_integrator_stage.sv
// One register-form CIC integrator: acc <= acc + din when enabled, modular wrap.
module cic_integrator_stage #(
  parameter int ACC_WIDTH = 28
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        i_en,
  input  logic signed [ACC_WIDTH-1:0] i_din,
  output logic signed [ACC_WIDTH-1:0] o_acc
);
  logic signed [ACC_WIDTH-1:0] r_acc;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + i_din;
    end
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/cic_decimator.sv
// CIC decimator by R = 2^dec_log2 with unity-gain normalising shift and saturation.
// Output registered one cycle after the decimating input; bypass passes input straight through.
module cic_decimator
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int STAGES       = 3,
  parameter int MAX_DEC_LOG2 = 4,
  parameter int ACC_WIDTH    = acc_width(DATA_WIDTH, STAGES, MAX_DEC_LOG2)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       bypass,
  input  logic [2:0] dec_log2,
  cic_decimator_if.slave s_if
);
  localparam int LW = (clog2(MAX_DEC_LOG2 + 1) > 0) ? clog2(MAX_DEC_LOG2 + 1) : 1;
  localparam int PW = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  logic [LW-1:0]               r_log2;
  logic                        r_armed;
  logic [PW-1:0]               r_phase;
  acc_t                        r_dly [STAGES];
  logic signed [DATA_WIDTH-1:0] r_y;
  logic                        r_vld;

  logic [LW-1:0]               w_log2_clamp;
  logic [LW-1:0]               w_log2;
  logic [PW-1:0]               w_rmask;
  logic                        w_upd;
  logic                        w_dec;
  acc_t                        w_int_in [STAGES];
  acc_t                        w_int [STAGES];
  acc_t                        w_cin [STAGES];
  acc_t                        w_cn;
  acc_t                        w_shifted;
  logic [7:0]                  w_shamt;
  logic signed [DATA_WIDTH-1:0] w_y_next;

  assign w_log2_clamp = (32'(dec_log2) > MAX_DEC_LOG2) ? LW'(MAX_DEC_LOG2) : LW'(dec_log2);
  // Until the first enabled clock after reset the live input is the active rate
  assign w_log2  = r_armed ? r_log2 : w_log2_clamp;
  assign w_rmask = ~({PW{1'b1}} << w_log2);
  assign w_upd   = EN && s_if.valid_in;
  assign w_dec   = w_upd && (r_phase == w_rmask);

  for (genvar k = 0; k < STAGES; k++) begin : g_int
    if (k == 0) begin : g_first
      assign w_int_in[k] = {{(ACC_WIDTH-DATA_WIDTH){s_if.x_in[DATA_WIDTH-1]}}, s_if.x_in};
    end else begin : g_chain
      assign w_int_in[k] = w_int[k-1];
    end
    cic_integrator_stage #(.ACC_WIDTH(ACC_WIDTH)) u_int (
      .CLK   (CLK),
      .RST   (RST),
      .i_en  (w_upd),
      .i_din (w_int_in[k]),
      .o_acc (w_int[k])
    );
  end

  always_comb begin
    acc_t w_acc_tmp;
    w_acc_tmp = w_int[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      w_cin[k]  = w_acc_tmp;
      w_acc_tmp = w_acc_tmp - r_dly[k];
    end
    w_cn = w_acc_tmp;
  end

  assign w_shamt   = 8'(STAGES) * 8'(w_log2);
  assign w_shifted = w_cn >>> w_shamt;
  assign w_y_next  = DATA_WIDTH'(sat_to_width(sat_t'(w_shifted), DATA_WIDTH));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_log2  <= '0;
      r_armed <= 1'b0;
      r_phase <= '0;
      r_y     <= '0;
      r_vld   <= 1'b0;
      for (int k = 0; k < STAGES; k++) r_dly[k] <= '0;
    end else begin
      r_vld <= w_dec;
      if (EN) r_armed <= 1'b1;
      if (EN && (!r_armed || w_dec)) r_log2 <= w_log2_clamp;
      if (w_upd) r_phase <= w_dec ? '0 : r_phase + PW'(1);
      if (w_dec) begin
        r_y <= w_y_next;
        for (int k = 0; k < STAGES; k++) r_dly[k] <= w_cin[k];
      end
    end
  end

  assign s_if.y_out     = bypass ? s_if.x_in : r_y;
  assign s_if.valid_out = bypass ? s_if.valid_in : (r_vld && EN);
endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator with hand-computed CIC outputs.
module tb_cic_decimator;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b1;
  logic       bypass = 1'b0;
  logic [2:0] dec_log2 = 3'd2;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cic_decimator_if #(.DATA_WIDTH(16)) u_if ();

  cic_decimator #(.DATA_WIDTH(16), .STAGES(3), .MAX_DEC_LOG2(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .bypass   (bypass),
    .dec_log2 (dec_log2),
    .s_if     (u_if)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] d);
    RST = 1'b0;
    EN = 1'b1;
    bypass = 1'b0;
    u_if.valid_in = 1'b0;
    u_if.x_in = '0;
    dec_log2 = d;
    tick();
    tick();
    RST = 1'b1;
  endtask

  // One valid_in cycle, then gap-1 idle cycles; reports the strobe seen after the input
  task automatic send(input logic signed [15:0] x, input int gap,
                      output logic vld, output logic signed [15:0] y, output int stray);
    u_if.x_in = x;
    u_if.valid_in = 1'b1;
    tick();
    vld = u_if.valid_out;
    y = u_if.y_out;
    u_if.valid_in = 1'b0;
    stray = 0;
    for (int g = 1; g < gap; g++) begin
      tick();
      if (u_if.valid_out) stray++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (u_if.y_out !== 16'sd0 || u_if.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got y=%0d v=%0b expected y=0 v=0", u_if.y_out, u_if.valid_out);
    end
  endtask

  task automatic test_dc();
    logic v; logic signed [15:0] y; int stray; int nout; int last;
    int exp_y[5] = '{15, 500, 984, 1000, 1000};
    nout = 0; last = -1;
    do_reset(3'd2);
    for (int i = 0; i < 20; i++) begin
      send(16'sd1000, 3, v, y, stray);
      checks++;
      if (v !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL dc_valid[%0d]: got %0b expected %0b", i, v, (i % 4 == 3));
      end
      checks++;
      if (stray != 0) begin
        errors++;
        $display("FAIL dc_strobe_width[%0d]: got %0d extra strobes expected 0", i, stray);
      end
      if (i % 4 == 3) begin
        checks++;
        if (y !== 16'(exp_y[nout])) begin
          errors++;
          $display("FAIL dc_y[%0d]: got %0d expected %0d", nout, y, exp_y[nout]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 12) begin
            errors++;
            $display("FAIL dc_period: got %0d cycles expected 12", cyc - last);
          end
        end
        last = cyc;
        nout++;
      end
    end
  endtask

  task automatic test_neg_fullscale();
    logic v; logic signed [15:0] y; int stray; int nout;
    int exp_y[5] = '{-3640, -25040, -32760, -32768, -32768};
    nout = 0;
    do_reset(3'd7);
    for (int i = 0; i < 80; i++) begin
      send(-16'sd32768, 1, v, y, stray);
      checks++;
      if (v !== (i % 16 == 15)) begin
        errors++;
        $display("FAIL neg_valid[%0d]: got %0b expected %0b", i, v, (i % 16 == 15));
      end
      if (i % 16 == 15) begin
        checks++;
        if (y !== 16'(exp_y[nout])) begin
          errors++;
          $display("FAIL neg_y[%0d]: got %0d expected %0d", nout, y, exp_y[nout]);
        end
        nout++;
      end
    end
  endtask

  task automatic test_back_to_back_r1();
    logic v; logic signed [15:0] y; int stray;
    logic signed [15:0] xs[8];
    do_reset(3'd0);
    for (int i = 0; i < 8; i++) xs[i] = (i % 2 == 0) ? 16'sd16384 : -16'sd16384;
    for (int i = 0; i < 8; i++) begin
      send(xs[i], 1, v, y, stray);
      checks++;
      if (v !== 1'b1 || y !== ((i < 3) ? 16'sd0 : xs[(i + 5) % 8])) begin
        errors++;
        $display("FAIL r1_out[%0d]: got v=%0b y=%0d expected v=1 y=%0d", i, v, y,
                 (i < 3) ? 16'sd0 : xs[(i + 5) % 8]);
      end
    end
    tick();
    checks++;
    if (u_if.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL r1_idle: got v=%0b expected 0", u_if.valid_out);
    end
  endtask

  task automatic test_rate_change();
    logic v; logic signed [15:0] y; int stray; int nout; logic exp_v;
    int exp_y[5] = '{7, 158, 465, 500, 500};
    nout = 0;
    do_reset(3'd2);
    for (int i = 0; i < 36; i++) begin
      if (i == 2) dec_log2 = 3'd3;
      send(16'sd500, 3, v, y, stray);
      exp_v = (i >= 3) && ((i - 3) % 8 == 0);
      checks++;
      if (v !== exp_v) begin
        errors++;
        $display("FAIL rate_valid[%0d]: got %0b expected %0b", i, v, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (y !== 16'(exp_y[nout])) begin
          errors++;
          $display("FAIL rate_y[%0d]: got %0d expected %0d", nout, y, exp_y[nout]);
        end
        nout++;
      end
    end
  endtask

  task automatic test_reset_mid_period();
    logic v; logic signed [15:0] y; int stray;
    do_reset(3'd3);
    for (int i = 0; i < 11; i++) send(16'sd1000, 3, v, y, stray);
    checks++;
    if (u_if.y_out !== 16'sd68) begin
      errors++;
      $display("FAIL rstmid_pre_y: got %0d expected 68", u_if.y_out);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (u_if.y_out !== 16'sd0 || u_if.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got y=%0d v=%0b expected y=0 v=0", u_if.y_out, u_if.valid_out);
    end
    tick();
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(16'sd1000, 3, v, y, stray);
      checks++;
      if (v !== (i == 7)) begin
        errors++;
        $display("FAIL rstmid_valid[%0d]: got %0b expected %0b", i, v, (i == 7));
      end
    end
    checks++;
    if (y !== 16'sd68) begin
      errors++;
      $display("FAIL rstmid_y: got %0d expected 68", y);
    end
  endtask

  task automatic test_bypass_enable();
    logic v; logic signed [15:0] y; int stray;
    do_reset(3'd2);
    bypass = 1'b1;
    u_if.x_in = 16'sh1234;
    u_if.valid_in = 1'b1;
    #1;
    checks++;
    if (u_if.y_out !== 16'sh1234 || u_if.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL bypass_pass: got y=%h v=%0b expected y=1234 v=1", u_if.y_out, u_if.valid_out);
    end
    u_if.valid_in = 1'b0;
    bypass = 1'b0;
    u_if.x_in = '0;
    #1;
    checks++;
    if (u_if.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL bypass_off: got v=%0b expected 0", u_if.valid_out);
    end
    tick();
    send(16'sd1000, 3, v, y, stray);
    send(16'sd1000, 3, v, y, stray);
    EN = 1'b0;
    for (int i = 0; i < 20; i++) begin
      u_if.x_in = 16'sd5000;
      u_if.valid_in = (i % 2 == 0);
      tick();
      checks++;
      if (u_if.valid_out !== 1'b0 || u_if.y_out !== 16'sd0) begin
        errors++;
        $display("FAIL en_hold[%0d]: got v=%0b y=%0d expected v=0 y=0", i, u_if.valid_out, u_if.y_out);
      end
    end
    u_if.valid_in = 1'b0;
    EN = 1'b1;
    tick();
    send(16'sd1000, 3, v, y, stray);
    checks++;
    if (v !== 1'b0) begin
      errors++;
      $display("FAIL en_resume_early: got v=%0b expected 0", v);
    end
    send(16'sd1000, 3, v, y, stray);
    checks++;
    if (v !== 1'b1 || y !== 16'sd15) begin
      errors++;
      $display("FAIL en_resume: got v=%0b y=%0d expected v=1 y=15", v, y);
    end
  endtask

  initial begin
    u_if.x_in = '0;
    u_if.valid_in = 1'b0;
    test_reset();
    test_dc();
    test_neg_fullscale();
    test_back_to_back_r1();
    test_rate_change();
    test_reset_mid_period();
    test_bypass_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
Multi-stage CIC decimator placed directly downstream of the fractional decimator in the DFE receive chain. It consumes that stage's y_m/valid strobe stream and decimates by a runtime-selectable power of two, R = 2^dec_log2. CIC gain is normalised back to unity by an arithmetic right shift. Output is a DATA_WIDTH sample with a one-cycle valid strobe, handed to the next stage.

Parameters:
DATA_WIDTH, 16, input/output sample width (signed Q1.15)
STAGES, 3, number of integrator and comb stages N (1..5)
MAX_DEC_LOG2, 4, largest supported log2(R), so R is at most 16
ACC_WIDTH, DATA_WIDTH+STAGES*MAX_DEC_LOG2, internal accumulator width (derived; do not override)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
EN  in  1  global enable; when low, all state freezes
bypass  in  1  1: pass input straight through
dec_log2  in  3  requested log2(R), 0..MAX_DEC_LOG2; values above the range clamp to MAX_DEC_LOG2
x_in  in  DATA_WIDTH  signed input sample (the fractional decimator's y_m)
valid_in  in  1  input sample strobe
y_out  out  DATA_WIDTH  signed decimated output
valid_out  out  1  single-cycle output strobe

Behaviour:
- Reset (RST low, asynchronous): all integrators, comb delays, the phase counter, y_out register and valid_out go to 0. The active R register loads the clamped dec_log2.
- A reset mid-period discards the partial period. The first output after reset requires a full R inputs.
- Sample update condition: EN && valid_in. Nothing updates without both.
- Integrators, register form: I1 <= I1 + sext(x_in); Ik <= Ik + I(k-1) using the old value.
- All integrator arithmetic is ACC_WIDTH two's complement with modular wrap. Overflow wrap is required and must not be flagged.
- Phase counter: 0..R-1, advances on each update condition.
- Decimation event: update condition while phase == R-1. Phase then wraps to 0.
- On a decimation event, comb chain computed combinationally from I_N (old value) in the same cycle: Ck = in_k - D_k, then D_k <= in_k. Comb differential delay M = 1.
- Output register: y_out <= sat_DATA_WIDTH(C_N >>> (STAGES*R_log2)), arithmetic shift. Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- valid_out is 1 for exactly the cycle after the decimation event, otherwise 0. Latency is 1 cycle from the decimating valid_in.
- y_out holds its value between strobes.
- dec_log2 changes are sampled only at a decimation event (or at reset), so a change takes effect for the next period. Integrator and comb state is not flushed; a transient of up to STAGES outputs is expected.
- R = 1 (dec_log2 = 0): every update is a decimation event, shift = 0.
- EN low: phase, integrators, combs and y_out hold; valid_out forced to 0.
- bypass = 1: y_out = x_in and valid_out = valid_in, both combinational. Internal state keeps running, so returning to bypass = 0 resumes without a reset.
- valid_in arriving on back-to-back cycles must be supported, although upstream delivers one sample every 3 EN cycles.

Decomposition:
- Shared package dfe_pkg:
  - function clog2
  - ACC_WIDTH derivation function
  - sat_to_width function (shared with other DFE stages)
- Natural sub-module: cic_integrator_stage (one ACC_WIDTH register-form integrator with enable), instantiated STAGES times via generate.
- Comb chain and output logic stay in the top level.

Test Plan:
- DC: R=4, N=3, x_in = 1000 on every valid_in, valid_in every 3rd cycle -> valid_out every 12 cycles, 1 cycle wide; y_out reaches 1000 exactly by the 4th output and stays at 1000.
- Full-scale negative DC: x_in = -32768, R=16 -> y_out settles to -32768 with no wrap artefacts, even though the integrators overflow many times.
- R=1 with alternating +16384/-16384 -> valid_out on every valid_in, 1 cycle later; y_out follows the input after the STAGES-sample pipeline fill.
- dec_log2 changed 2 -> 3 mid-period -> the current period still completes after 4 inputs; following periods span 8 inputs; DC 500 re-settles to 500.
- RST pulsed low mid-period with R=8 -> y_out=0 and valid_out=0 immediately; next valid_out only after 8 further valid_in.
- bypass=1 with x_in=0x1234 and valid_in pulse -> y_out=0x1234, valid_out=1 in the same cycle; EN=0 for 20 cycles -> no valid_out and state unchanged.
